// File: rtl/stopwatch_ctrl.sv
// Front-panel controller: debounces the start/stop and lap/reset buttons and sequences the stopwatch datapath.
// Optional lap freeze of the display is built when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES   = 4,
    parameter int unsigned SYNC_CHECK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic       run,
    output logic       sw_start,
    output logic       sw_stop,
    output logic       sw_reset,
    output logic [5:0] disp_seconds,
    output logic [5:0] disp_minutes,
    output logic       lap_active,
    output logic [1:0] state,
    output logic       sync_err
);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned WAIT_W = 3;
    localparam int unsigned SS     = 0;
    localparam int unsigned LR     = 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUNNING = 2'b01,
        S_PAUSED  = 2'b10
    } state_e;

    logic [1:0]       sync1_q, sync2_q, vld_q;
    logic [1:0]       level_q, level_d, armed_q, armed_d, press_q, press_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    state_e            state_q;
    logic              start_q, stop_q, reset_cmd_q, sync_err_q;
    logic [WAIT_W-1:0] chk_wait_q;
    logic [5:0]        disp_sec_q, disp_min_q;
`ifdef STOPWATCH_LAP_EN
    logic              lap_active_q;
    logic [5:0]        lap_sec_q, lap_min_q;
`endif

    // A rise only counts as a press once the button has been seen released since reset,
    // so a button held through reset release stays silent until pressed again.
    always_comb begin
        level_d = level_q;
        armed_d = armed_q;
        press_d = '0;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (vld_q[1] && !sync2_q[i]) armed_d[i] = 1'b1;
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt_d[i]   = '0;
                level_d[i] = sync2_q[i];
                press_d[i] = sync2_q[i] & armed_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            vld_q   <= '0;
            level_q <= '0;
            armed_q <= '0;
            press_q <= '0;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= {btn_lr, btn_ss};
            sync2_q <= sync1_q;
            vld_q   <= {vld_q[0], 1'b1};
            level_q <= level_d;
            armed_q <= armed_d;
            press_q <= press_d;
            for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Command FSM, display register and run/state consistency check.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            reset_cmd_q <= 1'b1;
            sync_err_q  <= 1'b0;
            chk_wait_q  <= WAIT_W'(SYNC_CHECK_CYCLES - 1);
            disp_sec_q  <= '0;
            disp_min_q  <= '0;
`ifdef STOPWATCH_LAP_EN
            lap_active_q <= 1'b0;
            lap_sec_q    <= '0;
            lap_min_q    <= '0;
`endif
        end else begin
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            reset_cmd_q <= 1'b0;

            if (chk_wait_q != '0) chk_wait_q <= chk_wait_q - WAIT_W'(1);
            else if (run != (state_q == S_RUNNING)) sync_err_q <= 1'b1;

`ifdef STOPWATCH_LAP_EN
            disp_sec_q <= lap_active_q ? lap_sec_q : seconds;
            disp_min_q <= lap_active_q ? lap_min_q : minutes;
`else
            disp_sec_q <= seconds;
            disp_min_q <= minutes;
`endif

            case (state_q)
                S_IDLE: begin
                    if (press_q[SS]) begin
                        start_q    <= 1'b1;
                        state_q    <= S_RUNNING;
                        chk_wait_q <= WAIT_W'(SYNC_CHECK_CYCLES - 1);
                    end else if (press_q[LR]) begin
                        reset_cmd_q <= 1'b1;
                        chk_wait_q  <= WAIT_W'(SYNC_CHECK_CYCLES - 1);
                    end
                end
                S_RUNNING: begin
                    if (press_q[SS]) begin
                        stop_q     <= 1'b1;
                        state_q    <= S_PAUSED;
                        chk_wait_q <= WAIT_W'(SYNC_CHECK_CYCLES - 1);
                    end
`ifdef STOPWATCH_LAP_EN
                    else if (press_q[LR]) begin
                        if (!lap_active_q) begin
                            lap_sec_q    <= seconds;
                            lap_min_q    <= minutes;
                            lap_active_q <= 1'b1;
                        end else begin
                            lap_active_q <= 1'b0;
                        end
                    end
`endif
                end
                S_PAUSED: begin
                    if (press_q[SS]) begin
                        start_q    <= 1'b1;
                        state_q    <= S_RUNNING;
                        chk_wait_q <= WAIT_W'(SYNC_CHECK_CYCLES - 1);
                    end else if (press_q[LR]) begin
                        reset_cmd_q <= 1'b1;
                        state_q     <= S_IDLE;
                        chk_wait_q  <= WAIT_W'(SYNC_CHECK_CYCLES - 1);
`ifdef STOPWATCH_LAP_EN
                        lap_active_q <= 1'b0;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sw_start     = start_q;
    assign sw_stop      = stop_q;
    assign sw_reset     = reset_cmd_q;
    assign disp_seconds = disp_sec_q;
    assign disp_minutes = disp_min_q;
    assign state        = state_q;
    assign sync_err     = sync_err_q;
`ifdef STOPWATCH_LAP_EN
    assign lap_active   = lap_active_q;
`else
    assign lap_active   = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: scenario tasks against a cycle-level behavioural model.
module tb_stopwatch_ctrl;
    localparam int DEB  = 4;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1, btn_ss = 1'b0, btn_lr = 1'b0, run = 1'b0;
    logic [5:0] seconds = '0, minutes = '0;
    logic       sw_start, sw_stop, sw_reset, lap_active, sync_err;
    logic [5:0] disp_seconds, disp_minutes;
    logic [1:0] state;
    logic [20:0] dut_vec;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(DEB), .SYNC_CHECK_CYCLES(SYNC)) dut (
        .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lr(btn_lr),
        .seconds(seconds), .minutes(minutes), .run(run),
        .sw_start(sw_start), .sw_stop(sw_stop), .sw_reset(sw_reset),
        .disp_seconds(disp_seconds), .disp_minutes(disp_minutes),
        .lap_active(lap_active), .state(state), .sync_err(sync_err)
    );

    assign dut_vec = {sw_start, sw_stop, sw_reset, state, lap_active, sync_err, disp_seconds, disp_minutes};

    // Reference model: state 0 idle, 1 running, 2 paused; debounce judged on a window of raw samples.
    int         n = 0;
    int         m_state = 0, m_lap_s = 0, m_lap_m = 0, m_disp_s = 0, m_disp_m = 0;
    bit         m_start = 0, m_stop = 0, m_rst = 1, m_lap = 0, m_err = 0;
    int         last_cmd = 0, last_rst = 0;
    bit         lvl [2];
    bit         armed [2];
    bit         press_prev [2];
    int         last_flip [2];
    logic [1:0] hist [$];
    logic [1:0] pat [$];
    int         prev_s = 0, prev_m = 0;

    function automatic logic [20:0] exp_vec();
        return {m_start, m_stop, m_rst, 2'(m_state), m_lap, m_err, 6'(m_disp_s), 6'(m_disp_m)};
    endfunction

    function automatic int rs();
        return int'($urandom_range(0, 59));
    endfunction

    task automatic model_edge(input logic r, input logic [1:0] raw, input logic rn, input int s, input int mi);
        bit all_diff, flip, smp, nxt_press [2];
        n++;
        if (r) begin
            m_state = 0; m_start = 0; m_stop = 0; m_rst = 1; m_lap = 0; m_err = 0;
            m_disp_s = 0; m_disp_m = 0; m_lap_s = 0; m_lap_m = 0;
            last_cmd = n; last_rst = n;
            for (int i = 0; i < 2; i++) begin
                lvl[i] = 0; armed[i] = 0; press_prev[i] = 0; last_flip[i] = n;
            end
            hist[hist.size() - 1] = 2'b00;
            hist.push_back(2'b00);
        end else begin
            if ((n - last_cmd >= SYNC) && (rn != (m_state == 1))) m_err = 1;
            if (m_lap) begin m_disp_s = m_lap_s; m_disp_m = m_lap_m; end
            else begin m_disp_s = s; m_disp_m = mi; end
            m_start = 0; m_stop = 0; m_rst = 0;
            if (press_prev[0]) begin
                if (m_state == 1) begin m_stop = 1; m_state = 2; end
                else begin m_start = 1; m_state = 1; end
                last_cmd = n;
            end else if (press_prev[1]) begin
                if (m_state == 0) begin m_rst = 1; last_cmd = n; end
                else if (m_state == 2) begin m_rst = 1; m_lap = 0; m_state = 0; last_cmd = n; end
                else begin
`ifdef STOPWATCH_LAP_EN
                    if (!m_lap) begin m_lap = 1; m_lap_s = s; m_lap_m = mi; end
                    else m_lap = 0;
`endif
                end
            end
            for (int i = 0; i < 2; i++) begin
                all_diff = 1;
                for (int k = 2; k <= DEB + 1; k++)
                    if (hist[hist.size() - k][i] == lvl[i]) all_diff = 0;
                flip = all_diff && (n - last_flip[i] >= DEB);
                smp  = hist[hist.size() - 2][i];
                nxt_press[i] = flip && !lvl[i] && armed[i];
                if ((n - last_rst >= 3) && !smp) armed[i] = 1;
                if (flip) begin lvl[i] = !lvl[i]; last_flip[i] = n; end
            end
            press_prev[0] = nxt_press[0];
            press_prev[1] = nxt_press[1];
            hist.push_back(raw);
        end
        if (hist.size() > 32) void'(hist.pop_front());
    endtask

    // One clock: drive on the falling edge, advance the model at the rising edge, settle 1 time unit.
    task automatic step(input logic r, input logic bs, input logic bl, input logic rn, input int s, input int mi);
        @(negedge clk);
        prev_s = s; prev_m = mi;
        reset = r; btn_ss = bs; btn_lr = bl; run = rn;
        seconds = 6'(s); minutes = 6'(mi);
        @(posedge clk);
        model_edge(r, {bl, bs}, rn, s, mi);
        #1;
    endtask

    task automatic pat_add(input logic [1:0] v, input int cnt);
        for (int i = 0; i < cnt; i++) pat.push_back(v);
    endtask

    task automatic do_reset(input int cycles);
        for (int c = 0; c < cycles; c++) step(1'b1, 1'b0, 1'b0, 1'b0, rs(), rs());
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, rs(), rs());
            checks++;
            if (sw_reset !== 1'b1 || sw_start !== 1'b0 || state !== 2'b00 || sync_err !== 1'b0 ||
                lap_active !== 1'b0 || disp_seconds !== 6'd0 || disp_minutes !== 6'd0) begin
                errors++; $display("FAIL reset_values edge=%0d got=%h", n, dut_vec);
            end
        end
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, rs(), rs());
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL held_across_reset edge=%0d got=%h exp=%h", n, dut_vec, exp_vec());
            end
            if (c == 0) begin
                checks++;
                if (sw_reset !== 1'b0) begin errors++; $display("FAIL reset_release sw_reset got=%b exp=0", sw_reset); end
            end
        end
        checks++;
        if (state !== 2'b00) begin errors++; $display("FAIL held_no_event state got=%b exp=00", state); end
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, rs(), rs());
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL reset_tail edge=%0d got=%h exp=%h", n, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_bounce();
        int cmds = 0;
        pat.delete();
        for (int r = 0; r < 5; r++) begin pat_add(2'b01, 3); pat_add(2'b00, 3); end
        foreach (pat[i]) begin
            step(1'b0, pat[i][0], pat[i][1], 1'b0, rs(), rs());
            cmds += int'(sw_start) + int'(sw_stop) + int'(sw_reset);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL bounce edge=%0d got=%h exp=%h", n, dut_vec, exp_vec());
            end
        end
        checks++;
        if (cmds != 0 || state !== 2'b00) begin
            errors++; $display("FAIL bounce_summary cmds=%0d state=%b exp cmds=0 state=00", cmds, state);
        end
    endtask

    task automatic test_clean_start();
        int e0 = -100;
        do_reset(2);
        pat.delete();
        pat_add(2'b00, 3); pat_add(2'b01, 10); pat_add(2'b00, 8);
        foreach (pat[i]) begin
            step(1'b0, pat[i][0], pat[i][1], m_state == 1, rs(), rs());
            if (i == 3) e0 = n;
            checks++;
            if (sw_start !== 1'(n == e0 + 6)) begin
                errors++; $display("FAIL start_latency edge=%0d e0=%0d got=%b", n, e0, sw_start);
            end
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL clean_start edge=%0d got=%h exp=%h", n, dut_vec, exp_vec());
            end
        end
        checks++;
        if (state !== 2'b01) begin errors++; $display("FAIL clean_start_state got=%b exp=01", state); end
    endtask

    task automatic test_full_sequence();
        int starts = 0, stops = 0, rsts = 0;
        do_reset(2);
        pat.delete();
        pat_add(2'b00, 3); pat_add(2'b01, 8); pat_add(2'b00, 8);
        pat_add(2'b01, 8); pat_add(2'b00, 8); pat_add(2'b10, 8); pat_add(2'b00, 8);
        foreach (pat[i]) begin
            step(1'b0, pat[i][0], pat[i][1], m_state == 1, rs(), rs());
            starts += int'(sw_start); stops += int'(sw_stop); rsts += int'(sw_reset);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL full_seq edge=%0d got=%h exp=%h", n, dut_vec, exp_vec());
            end
        end
        checks++;
        if (starts != 1 || stops != 1 || rsts != 1 || state !== 2'b00 || lap_active !== 1'b0) begin
            errors++;
            $display("FAIL full_seq_summary start=%0d stop=%0d reset=%0d state=%b lap=%b exp 1/1/1/00/0",
                     starts, stops, rsts, state, lap_active);
        end
    endtask

    task automatic test_simultaneous();
        int stops = 0, rsts = 0;
        do_reset(2);
        pat.delete();
        pat_add(2'b00, 3); pat_add(2'b01, 8); pat_add(2'b00, 8); pat_add(2'b11, 8); pat_add(2'b00, 8);
        foreach (pat[i]) begin
            step(1'b0, pat[i][0], pat[i][1], m_state == 1, rs(), rs());
            stops += int'(sw_stop); rsts += int'(sw_reset);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL simultaneous edge=%0d got=%h exp=%h", n, dut_vec, exp_vec());
            end
        end
        checks++;
        if (stops != 1 || rsts != 0 || state !== 2'b10 || lap_active !== 1'b0) begin
            errors++;
            $display("FAIL simultaneous_summary stop=%0d reset=%0d state=%b lap=%b exp 1/0/10/0",
                     stops, rsts, state, lap_active);
        end
    endtask

    task automatic test_sync_check();
        int ec = -100;
        do_reset(2);
        pat.delete();
        pat_add(2'b00, 3); pat_add(2'b01, 8); pat_add(2'b00, 12);
        foreach (pat[i]) begin
            step(1'b0, pat[i][0], pat[i][1], 1'b0, rs(), rs());
            if (sw_start === 1'b1) ec = n;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL sync_seq edge=%0d got=%h exp=%h", n, dut_vec, exp_vec());
            end
            if (ec > 0 && n == ec + 1) begin
                checks++;
                if (sync_err !== 1'b0) begin errors++; $display("FAIL sync_early got=%b exp=0", sync_err); end
            end
            if (ec > 0 && n >= ec + 2) begin
                checks++;
                if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_set edge=%0d got=%b exp=1", n, sync_err); end
            end
        end
        checks++;
        if (ec < 0) begin errors++; $display("FAIL sync_no_start got=none exp=one sw_start"); end
        for (int c = 0; c < 2; c++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, rs(), rs());
            checks++;
            if (sw_reset !== 1'b1) begin errors++; $display("FAIL sync_reset_hold got=%b exp=1", sw_reset); end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, rs(), rs());
        checks++;
        if (sync_err !== 1'b0 || state !== 2'b00 || sw_reset !== 1'b0) begin
            errors++; $display("FAIL sync_after_reset err=%b state=%b sw_reset=%b exp 0/00/0", sync_err, state, sw_reset);
        end
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic test_lap();
        do_reset(2);
        pat.delete();
        pat_add(2'b00, 3); pat_add(2'b01, 8); pat_add(2'b00, 8);
        foreach (pat[i]) step(1'b0, pat[i][0], pat[i][1], m_state == 1, rs(), rs());
        for (int c = 0; c < 8; c++) step(1'b0, 1'b0, 1'b1, 1'b1, 17, 2);
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, rs(), rs());
            checks++;
            if (disp_seconds !== 6'd17 || disp_minutes !== 6'd2 || lap_active !== 1'b1) begin
                errors++; $display("FAIL lap_hold got=%0d/%0d lap=%b exp=17/2 lap=1", disp_seconds, disp_minutes, lap_active);
            end
        end
        pat.delete();
        pat_add(2'b10, 8); pat_add(2'b00, 6);
        foreach (pat[i]) begin
            step(1'b0, pat[i][0], pat[i][1], 1'b1, rs(), rs());
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL lap_release edge=%0d got=%h exp=%h", n, dut_vec, exp_vec());
            end
        end
        checks++;
        if (lap_active !== 1'b0 || disp_seconds !== 6'(prev_s) || disp_minutes !== 6'(prev_m)) begin
            errors++; $display("FAIL lap_live got=%0d/%0d lap=%b exp=%0d/%0d lap=0",
                               disp_seconds, disp_minutes, lap_active, prev_s, prev_m);
        end
    endtask
`endif

    task automatic test_random();
        int total = 0;
        do_reset(2);
        while (total < 500) begin
            int kind = int'($urandom_range(0, 5));
            int len;
            logic [1:0] v;
            case (kind)
                0:       begin v = 2'b00; len = int'($urandom_range(1, 8)); end
                1:       begin v = 2'b01; len = int'($urandom_range(1, DEB - 1)); end
                2:       begin v = 2'b01; len = int'($urandom_range(DEB, DEB + 5)); end
                3:       begin v = 2'b10; len = int'($urandom_range(1, DEB + 5)); end
                4:       begin v = 2'b11; len = int'($urandom_range(DEB, DEB + 4)); end
                default: begin v = 2'b00; len = int'($urandom_range(DEB + 2, 10)); end
            endcase
            for (int c = 0; c < len; c++) begin
                logic rn = (m_state == 1);
                if ($urandom_range(0, 63) == 0) rn = ~rn;
                step(1'b0, v[0], v[1], rn, rs(), rs());
                total++;
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL random edge=%0d got=%h exp=%h", n, dut_vec, exp_vec());
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEB + 4; i++) hist.push_back(2'b00);
        test_reset();
        test_bounce();
        test_clean_start();
        test_full_sequence();
        test_simultaneous();
        test_sync_check();
`ifdef STOPWATCH_LAP_EN
        test_lap();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
